// File: rtl/ql_ser_pkg.sv
// ql_ser_pkg: shared types, baud table and TCTRL field positions for the QL serial transmitter.
package ql_ser_pkg;

    // Transmitter frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_t;

    // Baud rate for each TCTRL baud index
    localparam int BAUD_TAB [8] = '{19200, 9600, 4800, 2400, 1200, 600, 300, 75};

    // TCTRL register fields
    localparam int TCTRL_W        = 4;
    localparam int TCTRL_BAUD_LSB = 0;
    localparam int TCTRL_BAUD_MSB = 2;
    localparam int TCTRL_PORT_BIT = 3;

    // Clocks per bit, rounded to nearest; only ever called with constant arguments
    function automatic logic [19:0] baud_div(input int clk_hz, input logic [2:0] idx);
        int baud;
        baud = BAUD_TAB[idx];
        return 20'((clk_hz + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/ql_ser_fifo.sv
// ql_ser_fifo: small synchronous show-ahead FIFO for transmit bytes.
// dout always presents the oldest entry so it can be consumed on the pop clock.
module ql_ser_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; no reset so it maps onto distributed RAM
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; simultaneous push/pop keeps count
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/zx8302_ser_tx.sv
// zx8302_ser_tx: QL SER1/SER2 transmitter. Frames are 1 start, 8 data (LSB first), 2 stop.
// Build option QL_SER_FIFO_EN: buffer bytes in a FIFO_DEPTH-entry FIFO; otherwise a single
// holding register (as on the original chip) that frees up when a frame starts.
module zx8302_ser_tx
    import ql_ser_pkg::*;
#(
    parameter int CLK_HZ     = 21_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cep,
    input  logic       tctrl_we,
    input  logic       tdata_we,
    input  logic [7:0] din,
    input  logic       cts1,
    input  logic       cts2,
    output logic       txd1,
    output logic       txd2,
    output logic       busy,
    output logic       tx_irq
);
    // Divisor per baud index, folded to constants at elaboration
    logic [19:0] div_tab [8];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_div
            assign div_tab[gi] = baud_div(CLK_HZ, 3'(gi));
        end
    endgenerate

    logic [TCTRL_W-1:0] tctrl_reg;
    logic               cts1_meta_reg, cts1_sync_reg;
    logic               cts2_meta_reg, cts2_sync_reg;

    ser_state_t  state_reg, state_next;
    logic [19:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic        stop_cnt_reg, stop_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [19:0] div_reg, div_next;
    logic        port_reg, port_next;
    logic        tx_irq_reg, tx_irq_next;

    logic        push, pop, launch;
    logic        pending, busy_int;
    logic [7:0]  pend_data;
    logic [19:0] div_sel;
    logic        port_sel, cts_sel, txd_bit;

    assign div_sel  = div_tab[tctrl_reg[TCTRL_BAUD_MSB:TCTRL_BAUD_LSB]];
    assign port_sel = tctrl_reg[TCTRL_PORT_BIT];
    assign cts_sel  = port_sel ? cts2_sync_reg : cts1_sync_reg;
    assign push     = cep && tdata_we && !busy_int;

    // TCTRL register; only the low nibble is implemented
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tctrl_reg <= '0;
        end else if (cep && tctrl_we) begin
            tctrl_reg <= din[TCTRL_W-1:0];
        end
    end

    // Two-flop synchronizers for the asynchronous clear-to-send inputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cts1_meta_reg <= 1'b0;
            cts1_sync_reg <= 1'b0;
            cts2_meta_reg <= 1'b0;
            cts2_sync_reg <= 1'b0;
        end else begin
            cts1_meta_reg <= cts1;
            cts1_sync_reg <= cts1_meta_reg;
            cts2_meta_reg <= cts2;
            cts2_sync_reg <= cts2_meta_reg;
        end
    end

`ifdef QL_SER_FIFO_EN
    logic                          fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   unused_fifo_count;

    ql_ser_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .dout    (pend_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    assign busy_int = fifo_full;
    assign pending  = !fifo_empty;
`else
    logic [7:0] hold_reg;
    logic       hold_full_reg;
    logic       unused_cfg;

    assign unused_cfg = ^FIFO_DEPTH;

    // Single holding register: emptied when its byte moves into the shifter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_reg      <= 8'h00;
            hold_full_reg <= 1'b0;
        end else begin
            if (pop) begin
                hold_full_reg <= 1'b0;
            end
            if (push) begin
                hold_reg      <= din;
                hold_full_reg <= 1'b1;
            end
        end
    end

    assign busy_int  = hold_full_reg;
    assign pending   = hold_full_reg;
    assign pend_data = hold_reg;
`endif

    // Frame sequencer state and datapath registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= 8'h00;
            div_reg      <= '0;
            port_reg     <= 1'b0;
            tx_irq_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            stop_cnt_reg <= stop_cnt_next;
            shift_reg    <= shift_next;
            div_reg      <= div_next;
            port_reg     <= port_next;
            tx_irq_reg   <= tx_irq_next;
        end
    end

    // Next-state logic; a launch pops a byte and latches baud and port for the whole frame
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        stop_cnt_next = stop_cnt_reg;
        shift_next    = shift_reg;
        div_next      = div_reg;
        port_next     = port_reg;
        tx_irq_next   = 1'b0;
        launch        = 1'b0;
        pop           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pending && cts_sel) begin
                    launch = 1'b1;
                end
            end
            START: begin
                if (bit_cnt_reg == 20'd0) begin
                    state_next   = DATA;
                    bit_cnt_next = div_reg - 20'd1;
                    bit_idx_next = 3'd0;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 20'd1;
                end
            end
            DATA: begin
                if (bit_cnt_reg == 20'd0) begin
                    bit_cnt_next = div_reg - 20'd1;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next    = STOP;
                        stop_cnt_next = 1'b0;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 20'd1;
                end
            end
            STOP: begin
                if (bit_cnt_reg == 20'd0) begin
                    if (stop_cnt_reg) begin
                        if (pending && cts_sel) begin
                            launch = 1'b1;
                        end else begin
                            state_next  = IDLE;
                            tx_irq_next = 1'b1;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                        bit_cnt_next  = div_reg - 20'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 20'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (launch) begin
            state_next   = START;
            pop          = 1'b1;
            shift_next   = pend_data;
            div_next     = div_sel;
            port_next    = port_sel;
            bit_cnt_next = div_sel - 20'd1;
        end
    end

    // Line level for the active port; the other port idles high
    always_comb begin
        txd_bit = 1'b1;
        if (state_reg == START) begin
            txd_bit = 1'b0;
        end else if (state_reg == DATA) begin
            txd_bit = shift_reg[0];
        end
    end

    assign txd1   = port_reg | txd_bit;
    assign txd2   = ~port_reg | txd_bit;
    assign busy   = busy_int;
    assign tx_irq = tx_irq_reg;

endmodule

// File: tb/tb_zx8302_ser_tx.sv
// tb_zx8302_ser_tx: directed bench for zx8302_ser_tx at CLK_HZ=192000 (DIV 10 @19200, 20 @9600).
// Works with and without QL_SER_FIFO_EN defined.
module tb_zx8302_ser_tx;
    logic       clk_sys = 1'b0;
    logic       reset, cep, tctrl_we, tdata_we, cts1, cts2;
    logic [7:0] din;
    logic       txd1, txd2, busy, tx_irq;

    int n_cmp   = 0;
    int n_bad   = 0;
    int irq_cnt = 0;

    zx8302_ser_tx #(.CLK_HZ(192_000), .FIFO_DEPTH(8)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .cep      (cep),
        .tctrl_we (tctrl_we),
        .tdata_we (tdata_we),
        .din      (din),
        .cts1     (cts1),
        .cts2     (cts2),
        .txd1     (txd1),
        .txd2     (txd2),
        .busy     (busy),
        .tx_irq   (tx_irq)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (tx_irq === 1'b1) irq_cnt++;

    typedef struct {
        logic [7:0]  tctrl;
        logic [7:0]  data;
        logic        sel2;
        int          div;
        logic [10:0] frame;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wr_tctrl(input logic [7:0] v);
        cep = 1'b1; tctrl_we = 1'b1; din = v;
        @(negedge clk_sys);
        cep = 1'b0; tctrl_we = 1'b0;
    endtask

    task automatic wr_data(input logic [7:0] v);
        cep = 1'b1; tdata_we = 1'b1; din = v;
        @(negedge clk_sys);
        cep = 1'b0; tdata_we = 1'b0;
    endtask

    // Count clocks where txd1/txd2 leave idle over n clocks
    task automatic watch_idle(input string name, input int n);
        int lows;
        lows = 0;
        repeat (n) begin
            @(negedge clk_sys);
            if (txd1 !== 1'b1 || txd2 !== 1'b1) lows++;
        end
        check(name, lows, 0);
    endtask

    // Wait for a start bit, then check every clock of the 11-bit frame against the expected levels
    task automatic check_frame(input string name, input logic sel2, input logic [10:0] frame,
                               input int div, input logic mid_en, output int lat);
        int nbad;
        int nother;
        int s;
        lat = 0;
        nother = 0;
        do begin
            @(negedge clk_sys);
            lat++;
        end while ((sel2 ? txd2 : txd1) !== 1'b0 && lat < 300);
        if ((sel2 ? txd2 : txd1) !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s start: no start bit within %0d clks, required one", name, lat);
            return;
        end
        s = 0;
        for (int b = 0; b < 11; b++) begin
            nbad = 0;
            for (int c = 0; c < div; c++) begin
                if (s != 0) @(negedge clk_sys);
                if ((sel2 ? txd2 : txd1) !== frame[b]) nbad++;
                if ((sel2 ? txd1 : txd2) !== 1'b1) nother++;
                if (mid_en) begin
                    case (s)
                        5: begin cep = 1'b1; tctrl_we = 1'b1; din = 8'h07; end
                        6: begin tctrl_we = 1'b0; tdata_we = 1'b1; din = 8'h3C; end
                        7: begin cep = 1'b0; tdata_we = 1'b0; end
                        default: ;
                    endcase
                end
                s++;
            end
            n_cmp++;
            if (nbad != 0) begin
                n_bad++;
                $display("FAIL %s bit%0d: %0d of %0d clks differ from required level %b",
                         name, b, nbad, div, frame[b]);
            end
        end
        check({name, " other port idle"}, nother, 0);
        $display("%s: frame checked, start after %0d clk(s), div %0d", name, lat, div);
    endtask

    initial begin
        vec_t tab [4];
        int   lat, lat2, irq0;
        logic [7:0] b;

        tab[0] = '{8'h01, 8'hA5, 1'b0, 20, 11'b11_10100101_0};
        tab[1] = '{8'h08, 8'h00, 1'b1, 10, 11'b11_00000000_0};
        tab[2] = '{8'h09, 8'h3C, 1'b1, 20, 11'b11_00111100_0};
        tab[3] = '{8'h00, 8'hC3, 1'b0, 10, 11'b11_11000011_0};

        reset = 1'b1; cep = 1'b0; tctrl_we = 1'b0; tdata_we = 1'b0; din = 8'h00;
        cts1 = 1'b1; cts2 = 1'b1;
        tick(3);
        check("reset txd1", txd1, 1);
        check("reset txd2", txd2, 1);
        check("reset busy", busy, 0);
        check("reset tx_irq", tx_irq, 0);
        reset = 1'b0;
        tick(3);

        // Basic frames on both ports at two rates
        for (int i = 0; i < 4; i++) begin
            irq0 = irq_cnt;
            wr_tctrl(tab[i].tctrl);
            wr_data(tab[i].data);
            check_frame($sformatf("vec%0d", i), tab[i].sel2, tab[i].frame, tab[i].div, 1'b0, lat);
            tick(4);
            check($sformatf("vec%0d irq count", i), irq_cnt - irq0, 1);
        end

        // CTS low holds the byte; release starts the frame after the synchronizer delay
        cts1 = 1'b0;
        tick(4);
        wr_data(8'h55);
`ifdef QL_SER_FIFO_EN
        check("cts hold busy", busy, 0);
`else
        check("cts hold busy", busy, 1);
`endif
        watch_idle("cts hold line idle", 20);
        cts1 = 1'b1;
        check_frame("cts release", 1'b0, 11'b11_01010101_0, 10, 1'b0, lat);
        n_cmp++;
        if (lat < 3 || lat > 4) begin
            n_bad++;
            $display("FAIL cts latency: got %0d clks required 3..4", lat);
        end
        tick(4);

`ifdef QL_SER_FIFO_EN
        // Fill the FIFO with CTS low; the ninth byte must be dropped
        irq0 = irq_cnt;
        cts1 = 1'b0;
        tick(4);
        for (int i = 0; i < 9; i++) wr_data(8'(8'h10 + i));
        check("fifo full busy", busy, 1);
        cts1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'(8'h10 + i);
            check_frame($sformatf("fifo byte%0d", i), 1'b0, {2'b11, b, 1'b0}, 10, 1'b0, lat);
            if (i > 0) check($sformatf("fifo byte%0d gap", i), lat, 1);
        end
        watch_idle("fifo ninth dropped", 60);
        check("fifo irq count", irq_cnt - irq0, 1);
`else
        // Second byte fits once the first has moved to the shifter; third is dropped
        irq0 = irq_cnt;
        fork
            begin
                check_frame("hold 0x11", 1'b0, 11'b11_00010001_0, 10, 1'b0, lat);
                check_frame("hold 0x22", 1'b0, 11'b11_00100010_0, 10, 1'b0, lat2);
            end
            begin
                wr_data(8'h11);
                tick(2);
                wr_data(8'h22);
                wr_data(8'h33);
            end
        join
        check("hold back-to-back gap", lat2, 1);
        watch_idle("hold third dropped", 60);
        check("hold irq count", irq_cnt - irq0, 1);
`endif

        // TCTRL change mid-frame applies to the next frame only
        irq0 = irq_cnt;
        wr_tctrl(8'h00);
        fork
            begin
                check_frame("midrate 0xFF", 1'b0, 11'b11_11111111_0, 10, 1'b1, lat);
                check_frame("midrate 0x3C", 1'b0, 11'b11_00111100_0, 2560, 1'b0, lat2);
            end
            wr_data(8'hFF);
        join
        check("midrate back-to-back gap", lat2, 1);
        tick(4);
        check("midrate irq count", irq_cnt - irq0, 1);

        // Reset in the middle of the data bits
        wr_tctrl(8'h00);
        wr_data(8'hAA);
        tick(15);
        check("pre-reset data bit0", txd1, 0);
        wr_data(8'h5A);
`ifdef QL_SER_FIFO_EN
        check("pre-reset busy", busy, 0);
`else
        check("pre-reset busy", busy, 1);
`endif
        irq0 = irq_cnt;
        reset = 1'b1;
        @(negedge clk_sys);
        check("midframe reset txd1", txd1, 1);
        check("midframe reset busy", busy, 0);
        check("midframe reset tx_irq", tx_irq, 0);
        reset = 1'b0;
        watch_idle("after reset idle", 300);
        check("after reset irq count", irq_cnt - irq0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
